// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with a valid/ready handshake.
// Carries a control bundle, NUM_DATA data words and a destination register
// address. Supports start gating, flush to a bubble, and downstream stalls.
// With SKID=1 a second entry absorbs the one in-flight instruction that
// arrives while the downstream side stalls, so up_ready_o can be registered
// and no combinational ready path crosses the stage.

module pipe_stage_reg #(
    parameter int CTRL_W   = 4,
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 2,
    parameter int ADDR_W   = 5,
    parameter int SKID     = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         flush_i,
    input  logic                         up_valid_i,
    output logic                         up_ready_o,
    input  logic [CTRL_W-1:0]            ctrl_i,
    input  logic [NUM_DATA*DATA_W-1:0]   data_i,
    input  logic [ADDR_W-1:0]            rd_addr_i,
    output logic                         dn_valid_o,
    input  logic                         dn_ready_i,
    output logic [CTRL_W-1:0]            ctrl_o,
    output logic [NUM_DATA*DATA_W-1:0]   data_o,
    output logic [ADDR_W-1:0]            rd_addr_o,
    output logic [1:0]                   occupancy_o
);

    // Occupancy encoding doubles as the occupancy_o value.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_q, state_n;

    // Head entry (drives the outputs) and skid entry (SKID=1 only).
    logic [CTRL_W-1:0]          h_ctrl_q, s_ctrl_q;
    logic [NUM_DATA*DATA_W-1:0] h_data_q, s_data_q;
    logic [ADDR_W-1:0]          h_addr_q, s_addr_q;

    logic up_ready_q;
    logic h_valid;
    logic accept;
    logic drain;
    logic load_h_in;
    logic load_h_skid;
    logic load_s_in;

    assign h_valid = (state_q != ST_EMPTY);

    // Ready: registered from the next state with a skid entry, otherwise
    // combinational so a draining head can be replaced in the same cycle.
    assign up_ready_o = (SKID != 0) ? up_ready_q
                                    : (~h_valid | (dn_ready_i & start_i));

    assign accept = up_valid_i & up_ready_o & start_i & ~flush_i;
    assign drain  = h_valid & dn_ready_i & start_i;

    assign dn_valid_o  = h_valid;
    assign ctrl_o      = h_valid ? h_ctrl_q : '0;
    assign data_o      = h_data_q;
    assign rd_addr_o   = h_addr_q;
    assign occupancy_o = state_q;

    // Next-state and register-load decisions.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_n     = state_q;
        load_h_in   = 1'b0;
        load_h_skid = 1'b0;
        load_s_in   = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    load_h_in = 1'b1;
                    state_n   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    load_h_in = 1'b1;
                end else if (drain) begin
                    state_n = ST_EMPTY;
                end else if (accept && (SKID != 0)) begin
                    load_s_in = 1'b1;
                    state_n   = ST_FULL;
                end
            end
            ST_FULL: begin
                if (drain) begin
                    load_h_skid = 1'b1;
                    state_n     = ST_ONE;
                end
            end
            default: state_n = ST_EMPTY;
        endcase
        // Flush empties the stage; stored fields are left untouched so
        // data_o and rd_addr_o keep their last value behind the valid mask.
        if (flush_i) begin
            state_n     = ST_EMPTY;
            load_h_in   = 1'b0;
            load_h_skid = 1'b0;
            load_s_in   = 1'b0;
        end
    end

    // State, ready and entry storage registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: the payload registers are cleared on reset as well as the
        // state, because data_o and rd_addr_o must read zero after reset.
        if (!rst_i) begin
            state_q    <= ST_EMPTY;
            up_ready_q <= 1'b1;
            h_ctrl_q   <= '0;
            h_data_q   <= '0;
            h_addr_q   <= '0;
            s_ctrl_q   <= '0;
            s_data_q   <= '0;
            s_addr_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, e.g. H<=S and S<=input can never race.
            state_q    <= state_n;
            up_ready_q <= (state_n != ST_FULL);
            if (load_h_in) begin
                h_ctrl_q <= ctrl_i;
                h_data_q <= data_i;
                h_addr_q <= rd_addr_i;
            end else if (load_h_skid) begin
                h_ctrl_q <= s_ctrl_q;
                h_data_q <= s_data_q;
                h_addr_q <= s_addr_q;
            end
            if (load_s_in) begin
                s_ctrl_q <= ctrl_i;
                s_data_q <= data_i;
                s_addr_q <= rd_addr_i;
            end
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) with a valid/ready handshake.
- Carries a control bundle, NUM_DATA data words and a destination register address, with start gating, flush (bubble) and stall support.
- SKID=1 adds a second entry so a cache-miss stall on the downstream side never drops an in-flight instruction, with no combinational ready path across the stage.

Parameters:
CTRL_W, 4, width of control bundle (MemRead, MemWrite, RegWrite, MemtoReg, ...)
DATA_W, 32, width of one data word
NUM_DATA, 2, number of data words carried (e.g. ALU result and RS data2)
ADDR_W, 5, width of destination register address
SKID, 1, 0 = single entry with combinational up_ready_o; 1 = two-entry skid with registered up_ready_o

Ports:
clk_i  in  1  clock, all state updates on posedge
rst_i  in  1  synchronous reset, active-low
start_i  in  1  pipeline enable; 0 freezes accept and drain
flush_i  in  1  synchronous flush; discards all held and incoming entries
up_valid_i  in  1  upstream entry valid
up_ready_o  out  1  stage can accept
ctrl_i  in  CTRL_W  control bundle
data_i  in  NUM_DATA*DATA_W  data words, word k at bits [k*DATA_W +: DATA_W]
rd_addr_i  in  ADDR_W  destination register address
dn_valid_o  out  1  output entry valid
dn_ready_i  in  1  downstream accepts
ctrl_o  out  CTRL_W  control bundle, forced 0 when dn_valid_o=0
data_o  out  NUM_DATA*DATA_W  data words of head entry
rd_addr_o  out  ADDR_W  destination address of head entry
occupancy_o  out  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Handshake definitions:
  - Accept = up_valid_i & up_ready_o & start_i & ~flush_i.
  - Drain = dn_valid_o & dn_ready_i & start_i.
- Reset (rst_i=0 at posedge):
  - Both entries become invalid and all stored fields become 0.
  - dn_valid_o=0, ctrl_o=0, data_o=0, rd_addr_o=0, occupancy_o=0.
  - up_ready_o=1 in the cycle after reset.
  - Reset overrides flush_i and start_i.
- Storage: head register H plus, when SKID=1, skid register S. Outputs are driven from H only.
- Occupancy states: EMPTY (0), ONE (H valid), FULL (H and S valid; SKID=1 only).
- EMPTY:
  - Accept: H<=input, go to ONE.
  - Otherwise stay in EMPTY.
- ONE:
  - Accept and Drain: H<=input, stay in ONE.
  - Drain only: go to EMPTY.
  - Accept only: with SKID=1, S<=input and go to FULL; with SKID=0 this case cannot occur.
  - Neither: hold.
- FULL:
  - Drain: H<=S, go to ONE.
  - No Drain: hold.
  - Accept is impossible because up_ready_o=0.
- up_ready_o:
  - SKID=1: registered, equals ~(next state==FULL). No combinational path from dn_ready_i.
  - SKID=0: up_ready_o = ~H.valid | (dn_ready_i & start_i), combinational.
- Latency: accepted entry appears on the outputs the cycle after Accept. Entries leave in FIFO order; no reordering, no duplication.
- Flush (flush_i=1, rst_i=1):
  - Next state is EMPTY regardless of Drain/Accept; the incoming entry is discarded.
  - data_o and rd_addr_o hold their last value; ctrl_o=0 via the valid mask.
  - Flush acts even when start_i=0.
- start_i=0: no Accept and no Drain. State and outputs hold. up_ready_o holds its registered value (SKID=1).
- Stall: dn_ready_i=0 holds H stable; no output field changes while dn_valid_o=1 and dn_ready_i=0.
- Bubble: dn_valid_o=0 always presents ctrl_o=0, so downstream MemRead, MemWrite and RegWrite are inactive.
- occupancy_o is registered and equals the state encoding.

Test Plan:
1. Reset then pass-through: rst_i=0 for 2 cycles, then start_i=1, dn_ready_i=1, and entries ctrl=4'b1010, data={32'h1,32'hDEAD_BEEF}, rd=5'd7 on consecutive cycles → each appears on outputs exactly 1 cycle later; dn_valid_o=1; occupancy_o=1 steady; up_ready_o=1 throughout.
2. Stall fill (SKID=1): dn_ready_i=0 while entries A (rd=1) then B (rd=2) are offered → occupancy_o 1 then 2; up_ready_o=0 in the cycle after B is accepted; C held upstream. Raise dn_ready_i → outputs A, B, C in order, one per cycle; no loss.
3. Flush in FULL: occupancy_o=2 and up_valid_i=1, assert flush_i one cycle → next cycle dn_valid_o=0, ctrl_o=0, occupancy_o=0, up_ready_o=1; the offered entry never appears.
4. start_i=0 freeze: occupancy_o=1, dn_ready_i=1, up_valid_i=1, start_i=0 for 3 cycles → outputs and occupancy unchanged. Lower start_i together with flush_i → stage empties.
5. Reset mid-operation: FULL with rd=5'd9 at head, rst_i=0 → next cycle all outputs 0 and occupancy_o=0; the skid entry is lost.
6. SKID=0 instance: dn_ready_i=0 with H valid → up_ready_o=0 in the same cycle. dn_ready_i=1 with up_valid_i=1 → back-to-back transfer at one entry per cycle.
